// File: rtl/jb_dfe_tdm_antenna_combiner.sv
// TDM antenna combiner: buffers per-antenna sample streams in small lane FIFOs and
// re-interleaves them into one AXI4-Stream, emitting whole frames only.
module jb_dfe_tdm_antenna_combiner #(
    parameter int unsigned N_ANTENNAS  = 4,
    parameter int unsigned PRECISION   = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned START_LEVEL = 2
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   enable,
    input  logic                                   clr_status,
    input  logic [N_ANTENNAS-1:0]                  lane_tvalid,
    input  logic [N_ANTENNAS-1:0][2*PRECISION-1:0] lane_tdata,
    output logic [2*PRECISION-1:0]                 m_tdata,
    output logic [1:0]                             m_tuser,
    output logic                                   m_tlast,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    output logic [N_ANTENNAS-1:0]                  ovf_sticky,
    output logic [N_ANTENNAS-1:0]                  unf_sticky,
    output logic [1:0]                             state_o
);
    localparam int unsigned DATA_W = 2 * PRECISION;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_LEVEL);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_ANTENNAS - 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      ant_idx_q, ant_idx_d;
    logic [PTR_W-1:0]      wr_ptr_q [N_ANTENNAS];
    logic [PTR_W-1:0]      rd_ptr_q [N_ANTENNAS];
    logic [CNT_W-1:0]      cnt_q    [N_ANTENNAS];
    logic [DATA_W-1:0]     mem_q    [N_ANTENNAS][FIFO_DEPTH];

    logic [DATA_W-1:0]     m_tdata_q;
    logic [IDX_W-1:0]      m_tuser_q;
    logic                  m_tlast_q;
    logic                  m_tvalid_q;
    logic [N_ANTENNAS-1:0] ovf_q, unf_q;

    logic [N_ANTENNAS-1:0] lane_empty, lane_ready, push, pop, ovf_set, unf_set;
    logic [DATA_W-1:0]     sel_data;
    logic                  slot_free, run_en, frame_start, load;

    // Load/pop decisions for the output register and lane FIFOs
    always_comb begin
        lane_empty = '0;
        lane_ready = '0;
        sel_data   = '0;
        pop        = '0;
        push       = '0;
        ovf_set    = '0;
        unf_set    = '0;
        for (int k = 0; k < N_ANTENNAS; k++) begin
            lane_empty[k] = (cnt_q[k] == '0);
            lane_ready[k] = (cnt_q[k] >= CNT_START);
            if (ant_idx_q == IDX_W'(k)) begin
                sel_data = mem_q[k][rd_ptr_q[k]];
            end
        end
        slot_free   = !m_tvalid_q || m_tready;
        run_en      = (state_q == ST_RUN) && enable;
        frame_start = (ant_idx_q == '0);
        // A frame only starts when every lane can supply its beat, keeping frames atomic
        load        = slot_free && run_en && (!frame_start || !(|lane_empty));
        if (slot_free && run_en && frame_start) begin
            unf_set = lane_empty;
        end
        for (int k = 0; k < N_ANTENNAS; k++) begin
            pop[k]     = load && (ant_idx_q == IDX_W'(k));
            push[k]    = lane_tvalid[k] && (state_q != ST_IDLE) && ((cnt_q[k] != CNT_FULL) || pop[k]);
            ovf_set[k] = lane_tvalid[k] && (state_q != ST_IDLE) && (cnt_q[k] == CNT_FULL) && !pop[k];
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ant_idx_d = ant_idx_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_FILL;
            ST_FILL: if (&lane_ready) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (!enable && slot_free) begin
            state_d = ST_IDLE;
        end
        if (state_q == ST_IDLE) begin
            ant_idx_d = '0;
        end else if (load) begin
            ant_idx_d = (ant_idx_q == IDX_LAST) ? '0 : ant_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ant_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ant_idx_q <= ant_idx_d;
        end
    end

    // Lane FIFO pointers and occupancy; IDLE holds them flushed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_ANTENNAS; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < N_ANTENNAS; k++) begin
                if (state_q == ST_IDLE) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    cnt_q[k]    <= '0;
                end else begin
                    if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                    if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                    if (push[k] && !pop[k]) begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end else if (!push[k] && pop[k]) begin
                        cnt_q[k] <= cnt_q[k] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_ANTENNAS; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= lane_tdata[k];
        end
    end

    // AXI output register: payload frozen while a beat waits for m_tready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (slot_free) begin
            m_tvalid_q <= load;
            if (load) begin
                m_tdata_q <= sel_data;
                m_tuser_q <= ant_idx_q;
                m_tlast_q <= (ant_idx_q == IDX_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~{N_ANTENNAS{clr_status}}) | ovf_set;
            unf_q <= (unf_q & ~{N_ANTENNAS{clr_status}}) | unf_set;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tuser    = m_tuser_q;
    assign m_tlast    = m_tlast_q;
    assign m_tvalid   = m_tvalid_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;
    assign state_o    = state_q;

endmodule
